writeback_unit_l6: RTL and testbench
====================================

# writeback_unit_l6

Writeback stage downstream of the L6 execute units (ALU, multiplier, memory, control-flow). Collects one result per cycle from `p_num_pipes` X→W channels via round-robin arbitration, registers it, then in the following cycle writes the physical register file and broadcasts a completion notification to rename/ROB. No backpressure exists past this stage; every accepted result drains one cycle later.

## Interface
Parameters:
- `p_num_pipes`, 4: number of upstream execute units (≥1)
- `p_seq_num_bits`, 5: width of ROB sequence number
- `p_phys_addr_bits`, 6: width of physical register address

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `Ex[i].val`  in  1  result valid from execute unit i (one per pipe, `X__WIntf.W_intf`)
- `Ex[i].rdy`  out  1  result accepted from unit i this cycle
- `Ex[i].pc`  in  32  instruction PC
- `Ex[i].seq_num`  in  `p_seq_num_bits`  ROB sequence number
- `Ex[i].waddr`  in  5  architectural destination
- `Ex[i].wdata`  in  32  result data
- `Ex[i].wen`  in  1  result writes a register
- `Ex[i].preg`  in  `p_phys_addr_bits`  allocated physical destination
- `Ex[i].ppreg`  in  `p_phys_addr_bits`  previous physical mapping (freed at commit)
- `rf_wen`  out  1  physical register file write enable
- `rf_waddr`  out  `p_phys_addr_bits`  register file write address (= preg)
- `rf_wdata`  out  32  register file write data
- `complete.val`  out  1  completion notification valid (`CompleteNotif.pub`)
- `complete.seq_num`, `.waddr`, `.wen`, `.preg`, `.ppreg`  out  as above  completed instruction metadata

## Operation
- Arbitration: among pipes with `val=1`, grant exactly one per cycle, round-robin. Priority pointer `ptr` (`clog2(p_num_pipes)` bits); search order ptr, ptr+1, …, wrapping modulo `p_num_pipes`.
- `Ex[g].rdy=1` only for the granted pipe g; all other `rdy=0`. `rdy` is combinational from `val` and `ptr`; valid/ready combinational loop is forbidden on the upstream side (upstream must not make `val` depend on `rdy`).
- On grant: `ptr <= (g+1) mod p_num_pipes`. No grant: `ptr` holds.
- Transfer (val&rdy) latches {seq_num, waddr, wdata, wen, preg, ppreg} into output register `wb_reg` with `wb_reg.val=1`; no transfer clears `wb_reg.val`.
- Outputs from `wb_reg`: `complete.val = wb_reg.val`; `rf_wen = wb_reg.val & wb_reg.wen & (wb_reg.waddr != 0)`; `rf_waddr = wb_reg.preg`; `rf_wdata = wb_reg.wdata`.
- `complete` fires for every accepted result, including `wen=0` (branches, stores) and `waddr=0`.
- `pc` used for tracing only.
- Non-synthesis `trace(level)` function: level>0 prints pipe index, seq_num, waddr, wdata; level 0 prints seq_num; blank fixed width when idle.

## Timing
- Latency: accept in cycle N → `rf_wen`/`complete.val` asserted cycle N+1, exactly one cycle.
- Throughput: one result per cycle sustained; each of k continuously valid pipes served once every k cycles.
- Reset: `wb_reg.val=0`, `ptr=0`; all outputs `rf_wen=0`, `complete.val=0`, data outputs 0. During reset cycle all `rdy=0`.
- Reset asserted mid-operation: `wb_reg` contents dropped, no write/completion issued the following cycle.
- `p_num_pipes=1`: `rdy=val`, pointer constant 0.
- No valid inputs: outputs idle next cycle, pointer unchanged.

## Structure
- `wb_reg` packed struct typedef local to module; `CompleteNotif` interface added alongside `SquashNotif` in `intf/`.
- Sub-module `rr_arbiter_l6` (parameter `p_num_reqs`): inputs `clk`, `rst`, `req[p_num_reqs]`, `en`; output one-hot `gnt`; owns pointer; reusable by dispatch.
- Writeback mux (one-hot select of granted fields) in top module.

## Test plan
- Single result: pipe 2 val, seq 5, preg 12, waddr 3, wen 1, wdata 0xDEADBEEF → rdy2=1 cycle N; cycle N+1 rf_wen=1, rf_waddr=12, rf_wdata=0xDEADBEEF, complete.val=1, seq 5.
- Round-robin fairness: all 4 pipes valid for 8 cycles from reset → grants 0,1,2,3,0,1,2,3; each rdy one-hot.
- Pointer wrap/skip: after grant to pipe 3, only pipes 1 and 3 valid → grant 1, then 3, then 1.
- No-write cases: wen=0 (BNE) and wen=1 with waddr=0 → complete.val=1, rf_wen=0 both.
- Reset mid-stream: accept seq 7 cycle N, rst=1 cycle N+1 → complete.val=0 and rf_wen=0 in N+1 and N+2; first grant after reset goes to pipe 0.
- Back-to-back from one pipe: pipe 0 only, seq 1,2,3 consecutive → completes seq 1,2,3 on consecutive cycles, no bubbles.

Source files
------------

// File: rtl/writeback_unit_l6_pkg.sv
// writeback_unit_l6: shared widths and helpers
// Used by the writeback stage, its arbiter and interfaces.
package writeback_unit_l6_pkg;

  localparam int DATA_BITS = 32;
  localparam int ARCH_BITS = 5;

  typedef logic [DATA_BITS-1:0] data_t;
  typedef logic [ARCH_BITS-1:0] areg_t;

  function automatic int ptr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/writeback_unit_l6_intf.sv
// X->W result channel and completion notification
// Both carry ROB/rename metadata alongside the result.
interface X__WIntf #(
  parameter int p_seq_num_bits   = 5,
  parameter int p_phys_addr_bits = 6
) ();
  import writeback_unit_l6_pkg::*;

  logic                        val;
  logic                        rdy;
  data_t                       pc;
  logic [p_seq_num_bits-1:0]   seq_num;
  areg_t                       waddr;
  data_t                       wdata;
  logic                        wen;
  logic [p_phys_addr_bits-1:0] preg;
  logic [p_phys_addr_bits-1:0] ppreg;

  modport W_intf (
    input  val, pc, seq_num, waddr, wdata, wen, preg, ppreg,
    output rdy
  );
  modport X_intf (
    output val, pc, seq_num, waddr, wdata, wen, preg, ppreg,
    input  rdy
  );
endinterface

interface CompleteNotif #(
  parameter int p_seq_num_bits   = 5,
  parameter int p_phys_addr_bits = 6
) ();
  import writeback_unit_l6_pkg::*;

  logic                        val;
  logic [p_seq_num_bits-1:0]   seq_num;
  areg_t                       waddr;
  logic                        wen;
  logic [p_phys_addr_bits-1:0] preg;
  logic [p_phys_addr_bits-1:0] ppreg;

  modport pub (output val, seq_num, waddr, wen, preg, ppreg);
  modport sub (input  val, seq_num, waddr, wen, preg, ppreg);
endinterface

// File: rtl/writeback_unit_l6_rr_arbiter.sv
// rr_arbiter_l6: round-robin one-hot arbiter
// Pointer marks the highest-priority requester; advances past each grant.
module rr_arbiter_l6
  import writeback_unit_l6_pkg::*;
#(
  parameter int p_num_reqs = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [p_num_reqs-1:0] req,
  input  logic                  en,
  output logic [p_num_reqs-1:0] gnt
);

  localparam int PW = ptr_bits(p_num_reqs);

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] ptr_next;
  logic          found;

  // Two passes: requesters at or above ptr first, then wrap to the bottom.
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    for (int j = 0; j < p_num_reqs; j++) begin
      if (!found && req[j] && j >= int'(ptr)) begin
        found  = 1'b1;
        gidx   = PW'(j);
        gnt[j] = 1'b1;
      end
    end
    for (int j = 0; j < p_num_reqs; j++) begin
      if (!found && req[j]) begin
        found  = 1'b1;
        gidx   = PW'(j);
        gnt[j] = 1'b1;
      end
    end
    if (!en || rst) gnt = '0;
  end

  assign ptr_next = (gidx == PW'(p_num_reqs - 1)) ? '0 : gidx + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (|gnt) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/writeback_unit_l6.sv
// writeback_unit_l6: arbitrate execute results, write PRF, notify ROB
// One result accepted per cycle; it drains exactly one cycle later.
module writeback_unit_l6
  import writeback_unit_l6_pkg::*;
#(
  parameter int p_num_pipes      = 4,
  parameter int p_seq_num_bits   = 5,
  parameter int p_phys_addr_bits = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  X__WIntf.W_intf                     Ex [p_num_pipes],
  output logic                        rf_wen,
  output logic [p_phys_addr_bits-1:0] rf_waddr,
  output data_t                       rf_wdata,
  CompleteNotif.pub                   complete
);

  typedef struct packed {
    logic                        val;
    logic [p_seq_num_bits-1:0]   seq_num;
    areg_t                       waddr;
    data_t                       wdata;
    logic                        wen;
    logic [p_phys_addr_bits-1:0] preg;
    logic [p_phys_addr_bits-1:0] ppreg;
  } wb_t;

  logic [p_num_pipes-1:0] req;
  logic [p_num_pipes-1:0] gnt;
  wb_t                    cand [p_num_pipes];
  wb_t                    sel;
  wb_t                    wb_reg;
  wb_t                    wb_out;

  for (genvar i = 0; i < p_num_pipes; i++) begin : g_pipe
    assign req[i]    = Ex[i].val;
    assign Ex[i].rdy = gnt[i];
    assign cand[i]   = '{
      val:     Ex[i].val,
      seq_num: Ex[i].seq_num,
      waddr:   Ex[i].waddr,
      wdata:   Ex[i].wdata,
      wen:     Ex[i].wen,
      preg:    Ex[i].preg,
      ppreg:   Ex[i].ppreg
    };
  end

  rr_arbiter_l6 #(
    .p_num_reqs (p_num_pipes)
  ) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .en  (1'b1),
    .gnt (gnt)
  );

  // gnt is one-hot or zero, so OR-ing gated fields is the mux.
  always_comb begin
    sel = '0;
    for (int i = 0; i < p_num_pipes; i++) begin
      if (gnt[i]) sel = wb_t'(sel | cand[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_reg <= '0;
    end else begin
      wb_reg <= sel;
    end
  end

  // A reset cycle suppresses whatever is still held in wb_reg.
  assign wb_out = rst ? '0 : wb_reg;

  assign rf_wen   = wb_out.val & wb_out.wen & (wb_out.waddr != '0);
  assign rf_waddr = wb_out.preg;
  assign rf_wdata = wb_out.wdata;

  assign complete.val     = wb_out.val;
  assign complete.seq_num = wb_out.seq_num;
  assign complete.waddr   = wb_out.waddr;
  assign complete.wen     = wb_out.wen;
  assign complete.preg    = wb_out.preg;
  assign complete.ppreg   = wb_out.ppreg;

endmodule

// File: tb/tb_writeback_unit_l6.sv
// tb_writeback_unit_l6: scoreboard bench for the writeback stage
// Independent round-robin model predicts grants; queue holds completions.
module tb_writeback_unit_l6;

  localparam int N  = 4;
  localparam int SB = 5;
  localparam int PB = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          val_d   [N];
  logic [31:0]   pc_d    [N];
  logic [SB-1:0] seq_d   [N];
  logic [4:0]    wa_d    [N];
  logic [31:0]   wd_d    [N];
  logic          wen_d   [N];
  logic [PB-1:0] preg_d  [N];
  logic [PB-1:0] ppreg_d [N];
  logic [N-1:0]  rdy;

  logic          rf_wen;
  logic [PB-1:0] rf_waddr;
  logic [31:0]   rf_wdata;

  X__WIntf #(.p_seq_num_bits(SB), .p_phys_addr_bits(PB)) ex_if [N] ();
  CompleteNotif #(.p_seq_num_bits(SB), .p_phys_addr_bits(PB)) cn ();

  for (genvar i = 0; i < N; i++) begin : g_drv
    assign ex_if[i].val     = val_d[i];
    assign ex_if[i].pc      = pc_d[i];
    assign ex_if[i].seq_num = seq_d[i];
    assign ex_if[i].waddr   = wa_d[i];
    assign ex_if[i].wdata   = wd_d[i];
    assign ex_if[i].wen     = wen_d[i];
    assign ex_if[i].preg    = preg_d[i];
    assign ex_if[i].ppreg   = ppreg_d[i];
    assign rdy[i]           = ex_if[i].rdy;
  end

  writeback_unit_l6 #(
    .p_num_pipes      (N),
    .p_seq_num_bits   (SB),
    .p_phys_addr_bits (PB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .Ex       (ex_if),
    .rf_wen   (rf_wen),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .complete (cn)
  );

  typedef struct packed {
    logic          val;
    logic          rfw;
    logic [SB-1:0] seq;
    logic [4:0]    wa;
    logic [31:0]   wd;
    logic          wen;
    logic [PB-1:0] rfa;
    logic [PB-1:0] preg;
    logic [PB-1:0] ppreg;
  } obs_t;

  obs_t obs;
  assign obs = {cn.val, rf_wen, cn.seq_num, cn.waddr, rf_wdata,
                cn.wen, rf_waddr, cn.preg, cn.ppreg};

  obs_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   ptr_m  = 0;

  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int j;
      j = (ptr_m + k) % N;
      if (val_d[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic accept(input int g);
    obs_t e;
    e.val   = 1'b1;
    e.rfw   = wen_d[g] && (wa_d[g] != 5'd0);
    e.seq   = seq_d[g];
    e.wa    = wa_d[g];
    e.wd    = wd_d[g];
    e.wen   = wen_d[g];
    e.rfa   = preg_d[g];
    e.preg  = preg_d[g];
    e.ppreg = ppreg_d[g];
    sbq.push_back(e);
    ptr_m = (g + 1) % N;
  endtask

  task automatic set_pipe(input int i, input logic [SB-1:0] s,
                          input logic [4:0] wa, input logic [31:0] wd,
                          input logic we, input logic [PB-1:0] p,
                          input logic [PB-1:0] pp);
    val_d[i]   = 1'b1;
    pc_d[i]    = 32'h1000 + 32'(i * 4);
    seq_d[i]   = s;
    wa_d[i]    = wa;
    wd_d[i]    = wd;
    wen_d[i]   = we;
    preg_d[i]  = p;
    ppreg_d[i] = pp;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) val_d[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) set_pipe(i, '0, '0, '0, 1'b0, '0, '0);
    rst = 1'b1;
    tick();
    n_chk++;
    if (rdy !== '0) begin
      n_fail++;
      $display("FAIL reset_rdy: got %b want 0", rdy);
    end
    n_chk++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_out: got %h want 0", obs);
    end
    rst = 1'b0;
    idle_all();
    tick();
    n_chk++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: got %h want 0", obs);
    end
    sbq.delete();
    ptr_m = 0;
  endtask

  task automatic test_single();
    obs_t want;
    idle_all();
    set_pipe(2, 5'd5, 5'd3, 32'hDEADBEEF, 1'b1, 6'd12, 6'd20);
    #1;
    n_chk++;
    if (rdy !== 4'b0100 || rdy !== onehot(model_grant())) begin
      n_fail++;
      $display("FAIL single_rdy: got %b want 0100", rdy);
    end
    accept(2);
    tick();
    idle_all();
    want = {1'b1, 1'b1, 5'd5, 5'd3, 32'hDEADBEEF, 1'b1, 6'd12, 6'd12, 6'd20};
    n_chk++;
    if (obs !== want || obs !== sbq.pop_front()) begin
      n_fail++;
      $display("FAIL single_out: got %h want %h", obs, want);
    end
    tick();
    n_chk++;
    if (obs.val !== 1'b0 || obs.rfw !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain: got %h want idle", obs);
    end
  endtask

  task automatic test_rr();
    int   exp_g [9] = '{0, 1, 2, 3, 0, 1, 2, 3, -1};
    obs_t want;
    int   g;
    rst = 1'b1;
    idle_all();
    tick();
    rst = 1'b0;
    sbq.delete();
    ptr_m = 0;
    for (int c = 0; c < 9; c++) begin
      n_chk++;
      want = '0;
      if (sbq.size() > 0) want = sbq.pop_front();
      if (want.val ? (obs !== want) : (obs.val !== 1'b0 || obs.rfw !== 1'b0)) begin
        n_fail++;
        $display("FAIL rr_out c=%0d: got %h want %h", c, obs, want);
      end
      idle_all();
      if (c < 8) begin
        for (int i = 0; i < N; i++)
          set_pipe(i, SB'(c * 4 + i), 5'(i + 1), 32'hA5A50000 + 32'(c * 256 + i),
                   1'b1, PB'(c * 4 + i + 8), PB'(i + 40));
      end
      #1;
      g = model_grant();
      n_chk++;
      if (rdy !== onehot(g) || g != exp_g[c] || (c < 8 && !$onehot(rdy))) begin
        n_fail++;
        $display("FAIL rr_grant c=%0d: got %b want %b", c, rdy, onehot(exp_g[c]));
      end
      if (g >= 0) accept(g);
      tick();
    end
  endtask

  task automatic test_wrap();
    int   exp_g [4] = '{1, 3, 1, -1};
    obs_t want;
    int   g;
    for (int c = 0; c < 4; c++) begin
      n_chk++;
      want = '0;
      if (sbq.size() > 0) want = sbq.pop_front();
      if (want.val ? (obs !== want) : (obs.val !== 1'b0 || obs.rfw !== 1'b0)) begin
        n_fail++;
        $display("FAIL wrap_out c=%0d: got %h want %h", c, obs, want);
      end
      idle_all();
      if (c < 3) begin
        set_pipe(1, SB'(20 + c), 5'd7, 32'h11110000 + 32'(c), 1'b1, 6'd50, 6'd51);
        set_pipe(3, SB'(24 + c), 5'd9, 32'h33330000 + 32'(c), 1'b1, 6'd52, 6'd53);
      end
      #1;
      g = model_grant();
      n_chk++;
      if (rdy !== onehot(g) || g != exp_g[c]) begin
        n_fail++;
        $display("FAIL wrap_grant c=%0d: got %b want %b", c, rdy, onehot(exp_g[c]));
      end
      if (g >= 0) accept(g);
      tick();
    end
  endtask

  task automatic test_no_write();
    obs_t want;
    int   g;
    for (int c = 0; c < 3; c++) begin
      n_chk++;
      want = '0;
      if (sbq.size() > 0) want = sbq.pop_front();
      if (want.val ? (obs !== want) : (obs.val !== 1'b0 || obs.rfw !== 1'b0)) begin
        n_fail++;
        $display("FAIL nowr_out c=%0d: got %h want %h", c, obs, want);
      end
      if (c > 0 && (obs.val !== 1'b1 || rf_wen !== 1'b0)) begin
        n_fail++;
        $display("FAIL nowr_flags c=%0d: got val=%b wen=%b want 1 0", c, obs.val, rf_wen);
      end
      idle_all();
      if (c == 0) set_pipe(1, 5'd9, 5'd5, 32'h00000BAD, 1'b0, 6'd33, 6'd34);
      if (c == 1) set_pipe(1, 5'd10, 5'd0, 32'h00001234, 1'b1, 6'd35, 6'd36);
      #1;
      g = model_grant();
      n_chk++;
      if (rdy !== onehot(g)) begin
        n_fail++;
        $display("FAIL nowr_grant c=%0d: got %b want %b", c, rdy, onehot(g));
      end
      if (g >= 0) accept(g);
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int g;
    idle_all();
    set_pipe(2, 5'd7, 5'd4, 32'hCAFE0007, 1'b1, 6'd44, 6'd45);
    #1;
    g = model_grant();
    n_chk++;
    if (rdy !== onehot(g) || g != 2) begin
      n_fail++;
      $display("FAIL rmid_accept: got %b want 0100", rdy);
    end
    tick();
    rst = 1'b1;
    idle_all();
    set_pipe(1, 5'd8, 5'd4, 32'h1, 1'b1, 6'd1, 6'd2);
    set_pipe(3, 5'd9, 5'd4, 32'h3, 1'b1, 6'd3, 6'd4);
    #1;
    n_chk++;
    if (obs.val !== 1'b0 || rf_wen !== 1'b0 || rdy !== '0) begin
      n_fail++;
      $display("FAIL rmid_n1: got val=%b wen=%b rdy=%b want 0 0 0", obs.val, rf_wen, rdy);
    end
    sbq.delete();
    ptr_m = 0;
    tick();
    rst = 1'b0;
    n_chk++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL rmid_n2: got %h want 0", obs);
    end
    for (int i = 0; i < N; i++)
      set_pipe(i, SB'(i + 12), 5'(i + 2), 32'h77770000 + 32'(i), 1'b1, PB'(i + 16), PB'(i));
    #1;
    g = model_grant();
    n_chk++;
    if (rdy !== 4'b0001 || rdy !== onehot(g)) begin
      n_fail++;
      $display("FAIL rmid_first: got %b want 0001", rdy);
    end
    accept(g);
    tick();
    idle_all();
    n_chk++;
    if (obs !== sbq.pop_front()) begin
      n_fail++;
      $display("FAIL rmid_out: got %h want seq 12", obs);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int   exp_g [6] = '{0, 0, 0, -1, -1, 1};
    obs_t want;
    int   g;
    for (int c = 0; c < 7; c++) begin
      n_chk++;
      want = '0;
      if (sbq.size() > 0) want = sbq.pop_front();
      if (want.val ? (obs !== want) : (obs.val !== 1'b0 || obs.rfw !== 1'b0)) begin
        n_fail++;
        $display("FAIL b2b_out c=%0d: got %h want %h", c, obs, want);
      end
      if (c >= 1 && c <= 3 && obs.seq !== SB'(c)) begin
        n_fail++;
        $display("FAIL b2b_seq c=%0d: got %0d want %0d", c, obs.seq, c);
      end
      if (c == 6) break;
      idle_all();
      if (c < 3) set_pipe(0, SB'(c + 1), 5'd6, 32'hB0B00000 + 32'(c), 1'b1, 6'd60, 6'd61);
      if (c == 5) begin
        for (int i = 0; i < N; i++)
          set_pipe(i, SB'(i + 28), 5'd1, 32'(i), 1'b1, PB'(i), PB'(i));
      end
      #1;
      g = model_grant();
      n_chk++;
      if (rdy !== onehot(g) || g != exp_g[c]) begin
        n_fail++;
        $display("FAIL b2b_grant c=%0d: got %b want %b", c, rdy, onehot(exp_g[c]));
      end
      if (g >= 0) accept(g);
      tick();
    end
    idle_all();
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single();
    test_rr();
    test_wrap();
    test_no_write();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
